// File: rtl/lfsr_step_sequencer.sv
// lfsr_step_sequencer: owns the W/A/D register write port of the configurable LFSR block.
// Each accepted command stops the LFSR, programs polynomial and seed, then single-steps it
// cmd_count times and captures every new LFSR value into a small valid/ready output FIFO.
module lfsr_step_sequencer #(
  parameter int unsigned n         = 8,
  parameter int unsigned DEPTH     = 4,
  parameter logic [15:0] CTRL_ADDR = 16'h0010,
  parameter logic [15:0] POLY_ADDR = 16'h0012,
  parameter logic [15:0] SEED_ADDR = 16'h0014
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [n-1:0] cmd_poly,
  input  logic [n-1:0] cmd_seed,
  input  logic [15:0]  cmd_count,
  input  logic         abort,
  output logic         W,
  output logic [15:0]  A,
  output logic [n-1:0] D,
  input  logic [n-1:0] Q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_data,
  output logic         busy,
  output logic         done
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  typedef enum logic [3:0] {
    StIdle,
    StWrStop,
    StWrPoly,
    StWrSeed,
    StStepOn,
    StStepOff,
    StShiftWait,
    StCapture,
    StHold,
    StDone,
    StAbortStop
  } state_e;

  state_e state_q, state_d;

  logic [n-1:0] poly_q, seed_q;
  logic [15:0]  remaining_q;

  logic [n-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] fill_q, fill_d;

  logic accept;
  logic push;
  logic pop;
  logic abort_window;

  assign accept       = cmd_valid && cmd_ready;
  assign push         = (state_q == StCapture);
  assign out_valid    = (fill_q != '0);
  assign pop          = out_valid && out_ready;
  // Head is zero whenever the FIFO is empty so stale storage never shows on out_data.
  assign out_data     = out_valid ? mem_q[rd_ptr_q] : '0;
  assign abort_window = state_q inside {StWrPoly, StWrSeed, StStepOn, StStepOff,
                                        StShiftWait, StCapture, StHold};

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every transition inside the abort window.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:      if (cmd_valid) state_d = StWrStop;
      StWrStop:    state_d = StWrPoly;
      StWrPoly:    state_d = StWrSeed;
      StWrSeed:    state_d = (remaining_q == 16'd0) ? StDone : StStepOn;
      StStepOn:    state_d = StStepOff;
      StStepOff:   state_d = StShiftWait;
      StShiftWait: state_d = StCapture;
      StCapture: begin
        // Only step again when a slot is guaranteed free for the next capture.
        if (remaining_q == 16'd1) begin
          state_d = StDone;
        end else if (fill_d == FullCnt) begin
          state_d = StHold;
        end else begin
          state_d = StStepOn;
        end
      end
      StHold:      if (fill_q < FullCnt) state_d = StStepOn;
      StDone:      state_d = StIdle;
      StAbortStop: state_d = StIdle;
      default:     state_d = StIdle;
    endcase
    if (abort && abort_window) begin
      state_d = StAbortStop;
    end
  end

  // Decoded outputs: register-port writes, handshake and status.
  always_comb begin
    W         = 1'b0;
    A         = '0;
    D         = '0;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      StWrStop: begin
        W = 1'b1;
        A = CTRL_ADDR;
      end
      StWrPoly: begin
        W = 1'b1;
        A = POLY_ADDR;
        D = poly_q;
      end
      StWrSeed: begin
        W = 1'b1;
        A = SEED_ADDR;
        D = seed_q;
      end
      StStepOn: begin
        W = 1'b1;
        A = CTRL_ADDR;
        D = {{(n-1){1'b0}}, 1'b1};
      end
      StStepOff, StAbortStop: begin
        W = 1'b1;
        A = CTRL_ADDR;
      end
      StDone: done = 1'b1;
      default: ;
    endcase
  end

  // Command latch and remaining-sample counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      poly_q      <= '0;
      seed_q      <= '0;
      remaining_q <= '0;
    end else if (accept) begin
      poly_q      <= cmd_poly;
      seed_q      <= cmd_seed;
      remaining_q <= cmd_count;
    end else if (push) begin
      remaining_q <= remaining_q - 16'd1;
    end
  end

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    fill_d = fill_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + CntW'(1);
      2'b01:   fill_d = fill_q - CntW'(1);
      default: ;
    endcase
  end

  // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      fill_q <= fill_d;
    end
  end

  // FIFO storage; no reset needed since the head is masked while empty.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= Q;
    end
  end

endmodule

// File: tb/tb_lfsr_step_sequencer.sv
// Bench for lfsr_step_sequencer: behavioural LFSR block on the W/A/D/Q port, a negedge
// monitor logging writes, pops and done pulses, table vectors, corner sequences and a
// randomized run checked against an LFSR sequence computed from seed and polynomial.
module tb_lfsr_step_sequencer;

  localparam int unsigned N = 8;
  localparam int unsigned Depth = 4;
  localparam logic [15:0] CtrlAddr = 16'h0010;
  localparam logic [15:0] PolyAddr = 16'h0012;
  localparam logic [15:0] SeedAddr = 16'h0014;

  logic         clock = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [N-1:0] cmd_poly;
  logic [N-1:0] cmd_seed;
  logic [15:0]  cmd_count;
  logic         abort;
  logic         W;
  logic [15:0]  A;
  logic [N-1:0] D;
  logic [N-1:0] Q;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         busy;
  logic         done;

  always #5 clock = ~clock;

  lfsr_step_sequencer #(
    .n        (N),
    .DEPTH    (Depth),
    .CTRL_ADDR(CtrlAddr),
    .POLY_ADDR(PolyAddr),
    .SEED_ADDR(SeedAddr)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_poly (cmd_poly),
    .cmd_seed (cmd_seed),
    .cmd_count(cmd_count),
    .abort    (abort),
    .W        (W),
    .A        (A),
    .D        (D),
    .Q        (Q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .done     (done)
  );

  // Right-shifting Galois LFSR step.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s, input logic [7:0] p);
    return s[0] ? ((s >> 1) ^ p) : (s >> 1);
  endfunction

  // LFSR block model: a ctrl=1 write steps the register once, two edges after the write.
  logic [7:0] lf_poly, lf_q;
  logic       lf_ctrl, lf_ctrl_dly;
  always @(posedge clock) begin
    if (reset) begin
      lf_poly     <= '0;
      lf_q        <= '0;
      lf_ctrl     <= 1'b0;
      lf_ctrl_dly <= 1'b0;
    end else begin
      lf_ctrl_dly <= lf_ctrl;
      if (W && A == CtrlAddr) lf_ctrl <= D[0];
      if (W && A == PolyAddr) lf_poly <= D;
      if (W && A == SeedAddr) lf_q <= D;
      else if (lf_ctrl_dly) lf_q <= lfsr_next(lf_q, lf_poly);
    end
  end
  assign Q = lf_q;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [23:0] wl_q[$];
  int          wc_q[$];
  logic [7:0]  pd_q[$];
  int          pc_q[$];
  int          dn_q[$];
  logic        busy_after_done = 1'b1;
  logic        done_prev = 1'b0;

  // Monitor: sample everything mid-cycle.
  always @(negedge clock) begin
    if (W) begin
      wl_q.push_back({A, D});
      wc_q.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      pd_q.push_back(out_data);
      pc_q.push_back(cyc);
    end
    if (done_prev) busy_after_done = busy;
    if (done) dn_q.push_back(cyc);
    done_prev = done;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic clear_logs();
    wl_q.delete();
    wc_q.delete();
    pd_q.delete();
    pc_q.delete();
    dn_q.delete();
  endtask

  // Offer one command and return its accept cycle.
  task automatic send_cmd(input logic [7:0] p, input logic [7:0] s, input logic [15:0] c,
                          output int t);
    t = -1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b1;
    cmd_poly  = p;
    cmd_seed  = s;
    cmd_count = c;
    for (int k = 0; k < 100 && t < 0; k++) begin
      @(negedge clock);
      if (cmd_ready) t = cyc;
      else begin
        @(posedge clock);
        #1;
      end
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    chk("cmd_accepted", 32'(t >= 0), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int k = 0;
    @(negedge clock);
    while (busy && k < budget) begin
      @(posedge clock);
      #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      k++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
    #1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    @(negedge clock);
    while (out_valid && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk("fifo_drained", 32'(out_valid), 32'd0);
    #1;
  endtask

  typedef struct {
    logic [7:0] poly;
    logic [7:0] seed;
    int         count;
    int         exp_writes;
    int         exp_done_lat;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t, t1, t2;
    logic [23:0] exp_w[9];
    logic [7:0]  exp_q[$];
    logic [7:0]  s;

    vecs[0] = '{poly: 8'hB8, seed: 8'h80, count: 3, exp_writes: 9,  exp_done_lat: 16,
                exp_first: 8'h40, exp_last: 8'h10};
    vecs[1] = '{poly: 8'hB8, seed: 8'h80, count: 0, exp_writes: 3,  exp_done_lat: 4,
                exp_first: 8'h00, exp_last: 8'h00};
    vecs[2] = '{poly: 8'hB8, seed: 8'h01, count: 2, exp_writes: 7,  exp_done_lat: 12,
                exp_first: 8'hB8, exp_last: 8'h5C};
    vecs[3] = '{poly: 8'h8E, seed: 8'h03, count: 1, exp_writes: 5,  exp_done_lat: 8,
                exp_first: 8'h8F, exp_last: 8'h8F};
    vecs[4] = '{poly: 8'hB8, seed: 8'h80, count: 6, exp_writes: 15, exp_done_lat: 28,
                exp_first: 8'h40, exp_last: 8'h02};

    exp_w[0] = 24'h0010_00;
    exp_w[1] = 24'h0012_B8;
    exp_w[2] = 24'h0014_80;
    for (int i = 0; i < 3; i++) begin
      exp_w[3 + 2 * i] = 24'h0010_01;
      exp_w[4 + 2 * i] = 24'h0010_00;
    end

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_poly = '0;
    cmd_seed = '0;
    cmd_count = '0;
    abort = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_W", 32'(W), 32'd0);
    chk("rst_A", 32'(A), 32'd0);
    chk("rst_D", 32'(D), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Abort while idle is ignored.
    @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    @(negedge clock);
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_W", 32'(W), 32'd0);

    // Basic sequence with exact write order and sample timing.
    out_ready = 1'b1;
    clear_logs();
    send_cmd(8'hB8, 8'h80, 16'd3, t);
    wait_idle(200, 1'b0);
    drain(50);
    chk("basic_nwrites", 32'(wl_q.size()), 32'd9);
    for (int i = 0; i < 9; i++)
      if (i < wl_q.size()) chk($sformatf("basic_wr%0d", i), 32'(wl_q[i]), 32'(exp_w[i]));
    if (wc_q.size() > 0) chk("basic_wr_stop_cyc", 32'(wc_q[0] - t), 32'd1);
    chk("basic_npops", 32'(pd_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < pd_q.size()) begin
        chk($sformatf("basic_data%0d", i), 32'(pd_q[i]), 32'(8'h40 >> i));
        chk($sformatf("basic_cyc%0d", i), 32'(pc_q[i] - t), 32'(8 + 4 * i));
      end
    chk("basic_ndone", 32'(dn_q.size()), 32'd1);
    if (dn_q.size() > 0) chk("basic_done_cyc", 32'(dn_q[0] - t), 32'd16);
    chk("basic_busy_after_done", 32'(busy_after_done), 32'd0);

    // Table vectors.
    for (int v = 0; v < 5; v++) begin
      clear_logs();
      send_cmd(vecs[v].poly, vecs[v].seed, 16'(vecs[v].count), t);
      wait_idle(300, 1'b0);
      drain(50);
      chk($sformatf("vec%0d_nwrites", v), 32'(wl_q.size()), 32'(vecs[v].exp_writes));
      chk($sformatf("vec%0d_npops", v), 32'(pd_q.size()), 32'(vecs[v].count));
      chk($sformatf("vec%0d_ndone", v), 32'(dn_q.size()), 32'd1);
      if (dn_q.size() > 0)
        chk($sformatf("vec%0d_done_lat", v), 32'(dn_q[0] - t), 32'(vecs[v].exp_done_lat));
      if (pd_q.size() > 0) begin
        chk($sformatf("vec%0d_first", v), 32'(pd_q[0]), 32'(vecs[v].exp_first));
        chk($sformatf("vec%0d_last", v), 32'(pd_q[pd_q.size() - 1]), 32'(vecs[v].exp_last));
      end
    end

    // Backpressure: fill the FIFO, hold without stepping, then release.
    @(posedge clock);
    #1 out_ready = 1'b0;
    clear_logs();
    send_cmd(8'hB8, 8'h80, 16'd6, t);
    repeat (38) @(posedge clock);
    @(negedge clock);
    chk("bp_hold_nwrites", 32'(wl_q.size()), 32'd11);
    chk("bp_hold_npops", 32'(pd_q.size()), 32'd0);
    chk("bp_hold_ndone", 32'(dn_q.size()), 32'd0);
    chk("bp_hold_out_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_out_data", 32'(out_data), 32'h40);
    chk("bp_hold_busy", 32'(busy), 32'd1);
    @(posedge clock);
    #1 out_ready = 1'b1;
    wait_idle(300, 1'b0);
    drain(50);
    chk("bp_npops", 32'(pd_q.size()), 32'd6);
    s = 8'h80;
    for (int i = 0; i < 6; i++) begin
      s = lfsr_next(s, 8'hB8);
      if (i < pd_q.size()) chk($sformatf("bp_data%0d", i), 32'(pd_q[i]), 32'(s));
    end
    chk("bp_nwrites", 32'(wl_q.size()), 32'd15);
    chk("bp_ndone", 32'(dn_q.size()), 32'd1);

    // Abort during the third STEP_OFF.
    clear_logs();
    send_cmd(8'hB8, 8'h80, 16'd100, t);
    while (cyc < t + 13) begin
      @(posedge clock);
      #1;
    end
    abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    wait_idle(50, 1'b0);
    drain(20);
    chk("abort_nwrites", 32'(wl_q.size()), 32'd10);
    if (wl_q.size() > 0) begin
      chk("abort_last_wr", 32'(wl_q[wl_q.size() - 1]), 32'h0010_00);
      chk("abort_last_wr_cyc", 32'(wc_q[wc_q.size() - 1] - t), 32'd14);
    end
    chk("abort_npops", 32'(pd_q.size()), 32'd2);
    if (pd_q.size() == 2) begin
      chk("abort_data0", 32'(pd_q[0]), 32'h40);
      chk("abort_data1", 32'(pd_q[1]), 32'h20);
    end
    chk("abort_ndone", 32'(dn_q.size()), 32'd0);

    // Reset while holding with a full FIFO.
    @(posedge clock);
    #1 out_ready = 1'b0;
    clear_logs();
    send_cmd(8'hB8, 8'h80, 16'd10, t);
    while (cyc < t + 25) begin
      @(posedge clock);
      #1;
    end
    chk("rstmid_pre_nwrites", 32'(wl_q.size()), 32'd11);
    chk("rstmid_pre_out_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rstmid_out_valid", 32'(out_valid), 32'd0);
    chk("rstmid_W", 32'(W), 32'd0);
    chk("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rstmid_busy", 32'(busy), 32'd0);

    // Back-to-back: second command held valid while the first runs.
    @(posedge clock);
    #1 out_ready = 1'b1;
    clear_logs();
    cmd_valid = 1'b1;
    cmd_poly = 8'hB8;
    cmd_seed = 8'h80;
    cmd_count = 16'd2;
    t1 = -1;
    t2 = -1;
    for (int k = 0; k < 20 && t1 < 0; k++) begin
      @(negedge clock);
      if (cmd_ready) t1 = cyc;
    end
    @(posedge clock);
    #1;
    cmd_seed = 8'h01;
    cmd_count = 16'd1;
    for (int k = 0; k < 100 && t2 < 0; k++) begin
      @(negedge clock);
      if (cmd_ready) t2 = cyc;
    end
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    wait_idle(100, 1'b0);
    drain(20);
    chk("b2b_ndone", 32'(dn_q.size()), 32'd2);
    if (dn_q.size() > 0) chk("b2b_accept_after_done", 32'(t2 - dn_q[0]), 32'd1);
    chk("b2b_second_accept", 32'(t2 - t1), 32'd13);
    if (wl_q.size() > 7) begin
      chk("b2b_wr_stop", 32'(wl_q[7]), 32'h0010_00);
      chk("b2b_wr_stop_cyc", 32'(wc_q[7] - t2), 32'd1);
    end
    chk("b2b_npops", 32'(pd_q.size()), 32'd3);
    if (pd_q.size() == 3) begin
      chk("b2b_data0", 32'(pd_q[0]), 32'h40);
      chk("b2b_data1", 32'(pd_q[1]), 32'h20);
      chk("b2b_data2", 32'(pd_q[2]), 32'hB8);
    end

    // Randomized commands with random consumer backpressure.
    for (int r = 0; r < 8; r++) begin
      logic [7:0] rp, rs;
      int rc;
      rp = 8'($urandom);
      rs = 8'($urandom);
      rc = int'($urandom_range(1, 12));
      exp_q.delete();
      s = rs;
      for (int i = 0; i < rc; i++) begin
        s = lfsr_next(s, rp);
        exp_q.push_back(s);
      end
      clear_logs();
      send_cmd(rp, rs, 16'(rc), t);
      wait_idle(2000, 1'b1);
      drain(50);
      chk($sformatf("rnd%0d_npops", r), 32'(pd_q.size()), 32'(rc));
      for (int i = 0; i < rc; i++)
        if (i < pd_q.size()) chk($sformatf("rnd%0d_data%0d", r, i), 32'(pd_q[i]), 32'(exp_q[i]));
      chk($sformatf("rnd%0d_nwrites", r), 32'(wl_q.size()), 32'(3 + 2 * rc));
      chk($sformatf("rnd%0d_ndone", r), 32'(dn_q.size()), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
